// File: rtl/sfx_pkg.sv
// Shared encodings for the sound-effect scheduler: FSM states, effect indices,
// default effect lengths in AC97 sample frames.
package sfx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_PLAY  = 2'd2,
      ST_GAP   = 2'd3
   } state_t;

   localparam logic [1:0] FX_SLASH    = 2'd0;
   localparam logic [1:0] FX_RAMP     = 2'd1;
   localparam logic [1:0] FX_TRIANGLE = 2'd2;
   localparam logic [1:0] FX_BOING    = 2'd3;

   localparam int DUR_SLASH_DEF    = 8000;
   localparam int DUR_RAMP_DEF     = 16000;
   localparam int DUR_TRIANGLE_DEF = 16000;
   localparam int DUR_BOING_DEF    = 16000;
   localparam int GAP_DEF          = 2;

   localparam int CNT_W = 15;

endpackage

// File: rtl/sfx_frame_strobe.sv
// Brings the asynchronous AC97 frame-ready into the system clock domain and
// emits a one-cycle strobe per frame, three cycles after the ready rise.
module sfx_frame_strobe (
   input  logic clock_27mhz_i,
   input  logic reset_b_i,
   input  logic ready_i,
   output logic fs_o
);

   logic sync1_q, sync2_q, prev_q, fs_q;

   always_ff @(posedge clock_27mhz_i) begin
      if (!reset_b_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         sync1_q <= ready_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         fs_q    <= sync2_q & ~prev_q;
      end
   end

   assign fs_o = fs_q;

endmodule

// File: rtl/sfx_scheduler.sv
// Latches per-effect requests, arbitrates, issues one play pulse at a time and
// times each effect plus a silence gap in AC97 frames.
//  state    | meaning
//  ST_IDLE  | waiting for a pending request; winner picked here
//  ST_ISSUE | play pulse to the player, counter cleared
//  ST_PLAY  | counting frames until the effect length is reached
//  ST_GAP   | counting silence frames before the next effect
module sfx_scheduler
   import sfx_pkg::*;
#(
   parameter int DUR0 = DUR_SLASH_DEF,
   parameter int DUR1 = DUR_RAMP_DEF,
   parameter int DUR2 = DUR_TRIANGLE_DEF,
   parameter int DUR3 = DUR_BOING_DEF,
   parameter int GAP  = GAP_DEF,
   parameter int RR   = 1
) (
   input  logic       clock_27mhz,
   input  logic       reset_b,
   input  logic [3:0] req,
   input  logic       cancel,
   input  logic       ready,
   output logic [1:0] mode,
   output logic       play,
   output logic       busy,
   output logic [1:0] cur_fx,
   output logic [3:0] pending,
   output logic [3:0] dropped
);

   localparam logic [CNT_W-1:0] DUR0_W = CNT_W'(DUR0);
   localparam logic [CNT_W-1:0] DUR1_W = CNT_W'(DUR1);
   localparam logic [CNT_W-1:0] DUR2_W = CNT_W'(DUR2);
   localparam logic [CNT_W-1:0] DUR3_W = CNT_W'(DUR3);
   localparam logic [CNT_W-1:0] GAP_W  = CNT_W'(GAP);

   logic             fs;
   state_t           state_q, state_d;
   logic [3:0]       req_q, req_edge, clr_mask;
   logic [3:0]       pending_q, pending_d, dropped_q, dropped_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, dur_sel;
   logic [1:0]       ptr_q, ptr_d, cur_fx_q, cur_fx_d, mode_q, mode_d;
   logic [1:0]       win, idx;
   logic             win_vld;

   sfx_frame_strobe u_strobe (
      .clock_27mhz_i (clock_27mhz),
      .reset_b_i     (reset_b),
      .ready_i       (ready),
      .fs_o          (fs)
   );

   assign req_edge = req & ~req_q;
   assign cnt_inc  = cnt_q + 1'b1;

   always_comb begin
      case (cur_fx_q)
         FX_SLASH:    dur_sel = DUR0_W;
         FX_RAMP:     dur_sel = DUR1_W;
         FX_TRIANGLE: dur_sel = DUR2_W;
         FX_BOING:    dur_sel = DUR3_W;
         default:     dur_sel = DUR0_W;
      endcase
   end

   // Round-robin scans upward from the pointer with 2-bit wrap; fixed priority from 0.
   always_comb begin
      win     = 2'd0;
      win_vld = 1'b0;
      idx     = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = (RR != 0) ? ptr_q + 2'(k) : 2'(k);
         if (!win_vld && pending_q[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ptr_d    = ptr_q;
      cur_fx_d = cur_fx_q;
      mode_d   = mode_q;
      clr_mask = 4'b0000;
      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               clr_mask = 4'b0001 << win;
               cur_fx_d = win;
               mode_d   = win;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = '0;
            ptr_d   = cur_fx_q + 2'd1;
            state_d = ST_PLAY;
         end
         ST_PLAY: begin
            if (fs) begin
               if (cnt_inc == dur_sel) begin
                  cnt_d   = '0;
                  state_d = ST_GAP;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         ST_GAP: begin
            if (fs) begin
               if (cnt_inc == GAP_W) begin
                  cnt_d   = '0;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A fresh edge always survives both cancel and the serve-clear.
      pending_d = (cancel ? 4'b0000 : (pending_q & ~clr_mask)) | req_edge;
      dropped_d = dropped_q | (req_edge & pending_q & ~clr_mask);
   end

   always_ff @(posedge clock_27mhz) begin
      if (!reset_b) begin
         state_q   <= ST_IDLE;
         req_q     <= 4'b0000;
         pending_q <= 4'b0000;
         dropped_q <= 4'b0000;
         cnt_q     <= '0;
         ptr_q     <= 2'd0;
         cur_fx_q  <= 2'd0;
         mode_q    <= 2'd0;
      end else begin
         state_q   <= state_d;
         req_q     <= req;
         pending_q <= pending_d;
         dropped_q <= dropped_d;
         cnt_q     <= cnt_d;
         ptr_q     <= ptr_d;
         cur_fx_q  <= cur_fx_d;
         mode_q    <= mode_d;
      end
   end

   assign mode    = mode_q;
   assign play    = (state_q == ST_ISSUE);
   assign busy    = (state_q != ST_IDLE);
   assign cur_fx  = cur_fx_q;
   assign pending = pending_q;
   assign dropped = dropped_q;

endmodule

// File: tb/tb_sfx_scheduler.sv
// Scoreboard bench: stimulus pushes expected play modes, a negedge monitor pops
// and compares on every play pulse; directed checks cover capture, cancel, reset.
module tb_sfx_scheduler;

   logic       clk = 1'b0;
   logic       reset_b, cancel, ready;
   logic [3:0] req, req_fp;
   logic [1:0] mode, cur_fx, mode_fp, cur_fx_fp;
   logic       play, busy, play_fp, busy_fp;
   logic [3:0] pending, dropped, pending_fp, dropped_fp;

   int         n_checks = 0;
   int         n_pass   = 0;
   int         fs_cnt   = 0;
   int         rise_cnt = 0;
   bit         hold     = 1'b0;
   logic       hold_lvl = 1'b0;
   logic [1:0] exp_q[$];
   logic [1:0] exp_fp_q[$];
   logic [1:0] mon_e;

   always #5 clk = ~clk;

   sfx_scheduler #(.DUR0(4), .DUR1(6), .DUR2(6), .DUR3(6), .GAP(2), .RR(1)) u_main (
      .clock_27mhz (clk), .reset_b (reset_b), .req (req), .cancel (cancel),
      .ready (ready), .mode (mode), .play (play), .busy (busy),
      .cur_fx (cur_fx), .pending (pending), .dropped (dropped)
   );

   sfx_scheduler #(.DUR0(4), .DUR1(6), .DUR2(6), .DUR3(6), .GAP(2), .RR(0)) u_fp (
      .clock_27mhz (clk), .reset_b (reset_b), .req (req_fp), .cancel (cancel),
      .ready (ready), .mode (mode_fp), .play (play_fp), .busy (busy_fp),
      .cur_fx (cur_fx_fp), .pending (pending_fp), .dropped (dropped_fp)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic fail(input string name);
      n_checks++;
      $display("FAIL %s: got timeout/unexpected event, expected normal progress", name);
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse(input logic [3:0] m);
      step(); req = m;
      step(); req = 4'b0000;
   endtask

   task automatic wait_playing();
      for (int i = 0; i < 100; i++) begin
         step();
         if (busy && !play) return;
      end
      fail("wait_playing");
   endtask

   task automatic wait_idle(input bit fp, input int budget);
      for (int i = 0; i < budget; i++) begin
         step();
         if (fp ? (!busy_fp && pending_fp == 4'b0) : (!busy && pending == 4'b0)) return;
      end
      fail(fp ? "wait_idle_fp" : "wait_idle");
   endtask

   task automatic wait_ready(input logic lvl);
      for (int i = 0; i < 100; i++) begin
         step();
         if (ready == lvl) return;
      end
      fail("wait_ready");
   endtask

   task automatic measure_busy(output int n);
      n = 0;
      for (int i = 0; i < 50 && !busy; i++) step();
      for (int i = 0; i < 3000; i++) begin
         step();
         if (!busy) return;
         if (!play && u_main.u_strobe.fs_o) n++;
      end
      fail("measure_busy");
   endtask

   // AC97 ready: toggles every 20 cycles, can be parked at hold_lvl.
   initial begin
      ready = 1'b0;
      forever begin
         repeat (20) step();
         if (!(hold && ready == hold_lvl)) ready = ~ready;
      end
   end

   always @(posedge ready or negedge reset_b) begin
      if (!reset_b) rise_cnt = 0;
      else rise_cnt++;
   end

   always @(negedge clk) begin
      if (!reset_b) fs_cnt = 0;
      else if (u_main.u_strobe.fs_o) fs_cnt++;
      if (play) begin
         if (exp_q.size() == 0) fail("play_unexpected");
         else begin
            mon_e = exp_q.pop_front();
            check("play_mode", {30'd0, mode}, {30'd0, mon_e});
            check("play_cur_fx", {30'd0, cur_fx}, {30'd0, mon_e});
         end
      end
      if (play_fp) begin
         if (exp_fp_q.size() == 0) fail("play_fp_unexpected");
         else begin
            mon_e = exp_fp_q.pop_front();
            check("play_fp_mode", {30'd0, mode_fp}, {30'd0, mon_e});
         end
      end
   end

   initial begin
      int  n;
      int  snap;
      bit  found;
      reset_b = 1'b0; req = 4'b0; req_fp = 4'b0; cancel = 1'b0;
      repeat (3) step();
      check("rst_play", play, 0);
      check("rst_mode", mode, 0);
      check("rst_busy", busy, 0);
      check("rst_cur_fx", cur_fx, 0);
      check("rst_pending", pending, 0);
      check("rst_dropped", dropped, 0);
      reset_b = 1'b1;

      // single request, 6+2 frames busy
      step(); req = 4'b0100; exp_q.push_back(2'd2);
      step(); check("t1_pending", pending, 4'b0100); req = 4'b0000;
      measure_busy(n);
      check("t1_busy_fs", n, 8);
      check("t1_idle_pending", pending, 0);

      // fixed priority
      step(); req_fp = 4'b1010; exp_fp_q.push_back(2'd1); exp_fp_q.push_back(2'd3);
      step(); check("t2_fp_pending", pending_fp, 4'b1010); req_fp = 4'b0000;
      wait_idle(1, 2000);

      // round-robin from pointer 2
      exp_q.push_back(2'd1); pulse(4'b0010); wait_idle(0, 1000);
      exp_q.push_back(2'd3); exp_q.push_back(2'd0); exp_q.push_back(2'd1);
      pulse(4'b1011);
      check("t2_rr_pending", pending, 4'b1011);
      wait_idle(0, 3000);
      check("t2_rr_drained", exp_q.size(), 0);

      // queue during play and drop
      exp_q.push_back(2'd0); pulse(4'b0001); wait_playing();
      exp_q.push_back(2'd0); pulse(4'b0001);
      check("t3_requeue", pending, 4'b0001);
      check("t3_no_drop_yet", dropped, 4'b0000);
      pulse(4'b0001);
      check("t3_dropped", dropped, 4'b0001);
      wait_idle(0, 2000);
      check("t3_dropped_sticky", dropped, 4'b0001);

      // cancel
      exp_q.push_back(2'd0); pulse(4'b0001); wait_playing();
      pulse(4'b1110);
      check("t4_pending_pre", pending, 4'b1110);
      step(); cancel = 1'b1;
      step(); cancel = 1'b0;
      check("t4_cancelled", pending, 4'b0000);
      check("t4_still_busy", busy, 1);
      wait_idle(0, 2000);
      check("t4_no_more_play", exp_q.size(), 0);
      exp_q.push_back(2'd1); exp_q.push_back(2'd3);
      pulse(4'b0010); wait_playing();
      pulse(4'b0100);
      step(); cancel = 1'b1; req = 4'b1000;
      step(); cancel = 1'b0; req = 4'b0000;
      check("t4_cancel_edge", pending, 4'b1000);
      check("t4_dropped_kept", dropped, 4'b0001);
      wait_idle(0, 3000);

      // reset mid-play, with ready parked low around the reset
      exp_q.push_back(2'd2); pulse(4'b0100); wait_playing();
      pulse(4'b0001);
      wait_ready(1'b1); wait_ready(1'b0);
      repeat (4) step();
      reset_b = 1'b0;
      step();
      check("t5_play", play, 0);
      check("t5_busy", busy, 0);
      check("t5_pending", pending, 0);
      check("t5_dropped", dropped, 0);
      reset_b = 1'b1; req = 4'b0010; exp_q.push_back(2'd1);
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (k == 0) req = 4'b0000;
         if (play) found = 1'b1;
      end
      check("t5_play_latency", found, 1);
      wait_idle(0, 2000);

      // ready held high: no frames, effect stalls in PLAY
      exp_q.push_back(2'd3); pulse(4'b1000); wait_playing();
      hold_lvl = 1'b1; hold = 1'b1;
      wait_ready(1'b1);
      repeat (10) step();
      snap = fs_cnt;
      repeat (200) step();
      check("t6_no_fs", fs_cnt - snap, 0);
      check("t6_busy_held", busy, 1);
      hold = 1'b0;
      wait_idle(0, 3000);
      hold_lvl = 1'b0; hold = 1'b1;
      wait_ready(1'b0);
      repeat (10) step();
      check("t6_fs_vs_ready", fs_cnt, rise_cnt);
      check("end_queue", exp_q.size(), 0);
      check("end_queue_fp", exp_fp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sfx_scheduler.md
Name: sfx_scheduler

Overview:
- Sequences the sound-effect player, which plays one of four effects and takes a one-cycle play pulse plus a 2-bit mode.
- Game logic raises per-effect request lines. This block latches them as pending, arbitrates, and issues one play pulse at a time.
- It times each effect by counting AC97 sample frames, then inserts a silence gap before the next effect.
- Sits between game logic and the sfx player, in the clock_27mhz domain.

Parameters:
DUR0, 8000, effect 0 (slash) length in sample frames
DUR1, 16000, effect 1 (ramp) length in sample frames
DUR2, 16000, effect 2 (triangle) length in sample frames
DUR3, 16000, effect 3 (boing) length in sample frames
GAP, 2, silence frames between effects; must be >= 1
RR, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
clock_27mhz  in   1   system clock
reset_b      in   1   synchronous, active-low reset
req          in   4   per-effect request lines, level; a rising edge queues the effect
cancel       in   1   one-cycle pulse; clears all pending bits (does not stop the effect now playing)
ready        in   1   AC97 frame-ready, asynchronous (bit-clock domain)
mode         out  2   effect select to the player; valid while play=1, held otherwise
play         out  1   one-cycle start pulse to the player
busy         out  1   high in ISSUE, PLAY and GAP states
cur_fx       out  2   index of the effect being played or gapped
pending      out  4   latched, unserved requests
dropped      out  4   sticky; bit i sets when a req[i] edge arrives while pending[i] is already 1

Behaviour:
Reset values (reset_b=0 at a clock edge): state=IDLE, play=0, mode=0, cur_fx=0, busy=0, pending=0, dropped=0, frame counter=0, RR pointer=0, edge/sync flops=0. A reset mid-effect returns to IDLE immediately with no play pulse.

Frame strobe:
- ready passes through a 2-flop synchronizer, then a rising-edge detect.
- The result is a one-cycle fs strobe per AC97 frame.
- Latency from a ready rise to fs is 3 cycles.

Request capture:
- req is registered once; a rising edge (req & ~req_q) sets pending[i].
- If pending[i] is already 1, dropped[i] sets instead.
- cancel clears pending. If cancel and an edge land in the same cycle, the edge wins: the bit stays set.
- An edge for the effect currently playing queues normally.

State machine:
- IDLE: if pending != 0, select a winner w.
  - RR=1: first set bit at or after the pointer, wrapping 3->0.
  - RR=0: lowest set index.
  - Registered actions: clear pending[w] (unless a new req[w] edge arrives that same cycle), cur_fx=w, mode=w, go to ISSUE.
- ISSUE: play=1 for exactly this cycle; counter=0; pointer=(w+1) mod 4. Go to PLAY.
- PLAY: counter increments on each fs. When counter reaches DUR[cur_fx] (compare after increment), set counter=0 and go to GAP.
- GAP: counter increments on each fs. When counter reaches GAP, go to IDLE.
- Play timing:
  - Minimum spacing between play pulses is DUR+GAP frames.
  - A new winner can be chosen on the cycle IDLE is entered, so the next play is issued 2 cycles after GAP ends.
  - GAP >= 1 guarantees the player has returned to idle before the next play.
- Width rules:
  - Counter is 15 bits, enough for 16000 plus GAP.
  - Duration compare uses the parameter for cur_fx, selected with a case statement.
  - An fs arriving in IDLE or ISSUE is ignored.
- Outputs are registered; play is derived from state==ISSUE.

Decomposition:
- Shared package sfx_pkg: state encoding (IDLE, ISSUE, PLAY, GAP), effect index constants FX_SLASH=0, FX_RAMP=1, FX_TRIANGLE=2, FX_BOING=3, and default duration constants.
- One natural sub-module: sfx_frame_strobe (2-flop sync + edge detect on ready → fs).
- The arbiter stays inline.

Test Plan:
Run with DUR0=4, DUR1=DUR2=DUR3=6, GAP=2; ready toggles every 20 cycles.
1. Single request: pulse req[2] → pending=0100 next cycle; play=1 with mode=2 for one cycle; busy high for exactly 8 fs strobes; then IDLE with pending=0.
2. Fixed priority (RR=0): req=1010 in one cycle → plays effect 1, then effect 3. Round-robin (RR=1) with pointer at 2: req=1011 → order 3, 0, 1.
3. Queue during play: req[0] edge while effect 0 plays → pending=0001; effect 0 replays after 4+2 frames. A second req[0] edge before then → dropped=0001, which stays set until reset.
4. Cancel: pending=1110 during play, pulse cancel → pending=0000, the current effect completes, and no further play issues. Cancel coincident with a req[3] edge → pending=1000.
5. Reset mid-PLAY: reset_b=0 for one cycle → play=0, busy=0, pending=0, dropped=0. After release, a new req[1] is issued within 3 cycles.
6. Glitch-free ready: ready held high with no toggling → counter never advances and busy stays high (no timeout). fs count matches the ready rising-edge count exactly.
